aes_key_expand: RTL and testbench

Sequential AES-128 key schedule that sits directly upstream of the round datapath.
- Takes a 128-bit cipher key and emits round keys 0..10 in order over a valid/ready stream.
- Round key 10 feeds the final-round stage; keys 1..9 feed the middle rounds; key 0 feeds the initial AddRoundKey.
- One new round key is generated per accepted transfer, so there is no 11-key combinational cone.

---
 rtl/aes_key_expand_pkg.sv | 34 +++
 rtl/aes_key_expand_if.sv | 24 ++
 rtl/aes_subword.sv | 12 +
 rtl/aes_key_expand.sv | 140 ++++++++++++++
 tb/tb_aes_key_expand.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_expand_pkg.sv
// Shared definitions for the AES-128 key schedule: round count, Rcon constants,
// FSM encoding and the AES S-box table shared with the SubBytes datapath.
package aes_key_expand_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Entry 0 sits at the most significant end of the packed table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Control, round-key stream and key-store read bundle of aes_key_expand.
// master = requester/consumer side, slave = the key expander.
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key_in, rk_ready, rd_idx,
        input  busy, rk_valid, rk_out, rk_idx, done, rd_key
    );

    modport slave (
        input  start, key_in, rk_ready, rd_idx,
        output busy, rk_valid, rk_out, rk_idx, done, rd_key
    );
endinterface

// File: rtl/aes_subword.sv
// 32-bit SubWord: four parallel S-box lookups using the shared S-box table.
module aes_subword
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule emitting round keys 0..NR over a valid/ready stream.
// Optional round-key store enabled by defining AES_KEY_STORE_EN.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic             clk,
    input  logic             rst,
    aes_key_expand_if.slave  kx
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_e       state_r;
    logic [127:0] w_r;
    logic [3:0]   idx_r;
    logic [7:0]   rcon_r;
    logic         busy_r;
    logic         valid_r;
    logic         done_r;

    logic [31:0]  sub_s;
    logic [31:0]  t_s;
    logic [127:0] next_s;
    logic         start_acc_s;
    logic         xfer_s;
    logic         advance_s;

    // SubWord of RotWord(w3); RotWord moves the top byte to the bottom.
    aes_subword u_subword (
        .word_in  ({w_r[23:0], w_r[31:24]}),
        .word_out (sub_s)
    );

    // Next round key and handshake qualifiers.
    always_comb begin
        t_s            = sub_s ^ {rcon_r, 24'h000000};
        next_s[127:96] = w_r[127:96] ^ t_s;
        next_s[95:64]  = w_r[95:64]  ^ next_s[127:96];
        next_s[63:32]  = w_r[63:32]  ^ next_s[95:64];
        next_s[31:0]   = w_r[31:0]   ^ next_s[63:32];
        start_acc_s    = (state_r == IDLE) & kx.start;
        xfer_s         = (state_r == EMIT) & valid_r & kx.rk_ready;
        advance_s      = xfer_s & (idx_r != LAST_IDX);
    end

    // Expansion FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            w_r     <= 128'd0;
            idx_r   <= 4'd0;
            rcon_r  <= RCON_INIT;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_acc_s) begin
                        w_r     <= kx.key_in;
                        idx_r   <= 4'd0;
                        rcon_r  <= RCON_INIT;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b1;
                        state_r <= EMIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EMIT: begin
                    done_r <= 1'b0;
                    if (advance_s) begin
                        w_r    <= next_s;
                        idx_r  <= idx_r + 4'd1;
                        rcon_r <= xtime(rcon_r);
                    end else if (xfer_s) begin
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign kx.busy     = busy_r;
    assign kx.rk_valid = valid_r;
    assign kx.rk_out   = w_r;
    assign kx.rk_idx   = idx_r;
    assign kx.done     = done_r;

`ifdef AES_KEY_STORE_EN
    logic [127:0] bank_r [0:NR];
    logic [127:0] rd_key_s;

    // Round-key bank: slot 0 on accepted start, slot idx+1 as each key is generated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) bank_r[i] <= 128'd0;
        end else if (start_acc_s) begin
            for (int i = 1; i <= NR; i++) bank_r[i] <= 128'd0;
            bank_r[0] <= kx.key_in;
        end else if (advance_s) begin
            bank_r[idx_r + 4'd1] <= next_s;
        end else begin
            bank_r[0] <= bank_r[0];
        end
    end

    // Out-of-range read indices return zero.
    always_comb begin
        rd_key_s = 128'd0;
        if (kx.rd_idx <= LAST_IDX) begin
            rd_key_s = bank_r[kx.rd_idx];
        end else begin
            rd_key_s = 128'd0;
        end
    end

    assign kx.rd_key = rd_key_s;
`else
    logic unused_rd_idx_s;

    assign unused_rd_idx_s = ^kx.rd_idx;
    assign kx.rd_key       = 128'd0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 and all-zero key vectors,
// stalls, ignored start, mid-run reset, key store and back-to-back starts.
module tb_aes_key_expand;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_expand_if kx ();

    aes_key_expand dut (
        .clk (clk),
        .rst (rst),
        .kx  (kx)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    exp_t sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    logic         prev_stall = 1'b0;
    logic [127:0] prev_out   = 128'd0;
    logic [3:0]   prev_idx   = 4'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_fips(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back('{4'(i), fips_rk[i], 1'b1});
    endtask

    task automatic push_zero();
        sb_q.push_back('{4'd0, 128'd0, 1'b1});
        sb_q.push_back('{4'd1, 128'h62636363626363636263636362636363, 1'b1});
        for (int i = 2; i <= 10; i++) sb_q.push_back('{4'(i), 128'd0, 1'b0});
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold-during-stall.
    always @(negedge clk) begin
        if (!rst && kx.rk_valid) begin
            if (prev_stall) begin
                check("stall_hold_key", kx.rk_out, prev_out);
                check("stall_hold_idx", 128'(kx.rk_idx), 128'(prev_idx));
            end
            if (kx.rk_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_key_idx", 128'(kx.rk_idx), 128'hf);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rk_idx", 128'(kx.rk_idx), 128'(e.idx));
                    if (e.chk_key) check("rk_out", kx.rk_out, e.key);
                end
            end
        end
        prev_stall = !rst && kx.rk_valid && !kx.rk_ready;
        prev_out   = kx.rk_out;
        prev_idx   = kx.rk_idx;
    end

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_start(input logic [127:0] k);
        kx.key_in = k;
        kx.start  = 1'b1;
        @(posedge clk); #1;
        kx.start  = 1'b0;
        check("first_valid", 128'(kx.rk_valid), 128'd1);
        check("first_idx", 128'(kx.rk_idx), 128'd0);
        check("busy_after_start", 128'(kx.busy), 128'd1);
    endtask

    // Runs until done is seen (left at that sample point) or the cycle budget expires.
    task automatic wait_done(input logic [3:0] pat, input bit poke, output int nvalid, output bit got);
        bit poked;
        poked  = 1'b0;
        nvalid = 0;
        got    = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (kx.done) begin
                got = 1'b1;
            end else begin
                if (kx.rk_valid) nvalid++;
                if (poke && !poked && kx.rk_valid && kx.rk_idx == 4'd4) begin
                    kx.start  = 1'b1;
                    kx.key_in = ALT_KEY;
                    poked     = 1'b1;
                end else begin
                    kx.start = 1'b0;
                end
                kx.rk_ready = pat[c % 4];
                @(posedge clk); #1;
            end
        end
        kx.start = 1'b0;
        check("done_seen", 128'(got), 128'd1);
    endtask

    task automatic end_of_run(input string tag);
        check({tag, "_done_valid_low"}, 128'(kx.rk_valid), 128'd0);
        check({tag, "_done_busy_low"}, 128'(kx.busy), 128'd0);
        check({tag, "_sb_drained"}, 128'(sb_q.size()), 128'd0);
    endtask

    initial begin
        int nv;
        bit got;
        bit found;
        kx.start    = 1'b0;
        kx.key_in   = 128'd0;
        kx.rk_ready = 1'b0;
        kx.rd_idx   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(kx.rk_valid), 128'd0);
        check("rst_busy", 128'(kx.busy), 128'd0);
        check("rst_done", 128'(kx.done), 128'd0);
        check("rst_rk_out", kx.rk_out, 128'd0);
        check("rst_rk_idx", 128'(kx.rk_idx), 128'd0);
        check("rst_rd_key", kx.rd_key, 128'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 key, ready held high.
        kx.rk_ready = 1'b1;
        push_fips(11);
        do_start(FIPS_KEY);
        wait_done(4'b1111, 1'b0, nv, got);
        check("valid_cycles", 128'(nv), 128'd11);
        end_of_run("fips");
        @(posedge clk); #1;
        check("done_one_cycle", 128'(kx.done), 128'd0);

`ifdef AES_KEY_STORE_EN
        kx.rd_idx = 4'd10; #1;
        check("store_idx10", kx.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        kx.rd_idx = 4'd0; #1;
        check("store_idx0", kx.rd_key, FIPS_KEY);
        kx.rd_idx = 4'd12; #1;
        check("store_idx12", kx.rd_key, 128'd0);
`else
        kx.rd_idx = 4'd10; #1;
        check("rd_key_tied", kx.rd_key, 128'd0);
`endif
        @(posedge clk); #1;

        // Same key with rk_ready pattern 1,0,0,1.
        push_fips(11);
        do_start(FIPS_KEY);
        wait_done(4'b1001, 1'b0, nv, got);
        end_of_run("stall");
        @(posedge clk); #1;

        // start pulsed at idx 4 with another key must be ignored.
        kx.rk_ready = 1'b1;
        push_fips(11);
        do_start(FIPS_KEY);
        wait_done(4'b1111, 1'b1, nv, got);
        end_of_run("ignore_start");
        @(posedge clk); #1;

        // Reset while idx 6 is presented; keys 0..5 already accepted.
        push_fips(6);
        do_start(FIPS_KEY);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (kx.rk_valid && kx.rk_idx == 4'd6) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reached_idx6", 128'(found), 128'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 128'(kx.rk_valid), 128'd0);
        check("midrst_busy", 128'(kx.busy), 128'd0);
        check("midrst_done", 128'(kx.done), 128'd0);
        check("midrst_sb_drained", 128'(sb_q.size()), 128'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        push_zero();
        do_start(128'd0);
        wait_done(4'b1111, 1'b0, nv, got);
        end_of_run("zero_key");
        @(posedge clk); #1;

        // Back-to-back: start raised in the done cycle.
        push_fips(11);
        do_start(FIPS_KEY);
        wait_done(4'b1111, 1'b0, nv, got);
        end_of_run("b2b_first");
        push_zero();
        kx.key_in = 128'd0;
        kx.start  = 1'b1;
        @(posedge clk); #1;
        kx.start  = 1'b0;
        check("b2b_valid", 128'(kx.rk_valid), 128'd1);
        check("b2b_idx", 128'(kx.rk_idx), 128'd0);
        check("b2b_done_low", 128'(kx.done), 128'd0);
        wait_done(4'b1111, 1'b0, nv, got);
        end_of_run("b2b_second");
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
